// File: rtl/ascii_hex_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ascii_hex_pkg                                                   |
// | Purpose  : ASCII constants, transmit state type and nibble/ASCII helpers   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package ascii_hex_pkg;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_UA = 8'h41;
  localparam logic [7:0] ASCII_LA = 8'h61;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_DIG  = 2'd1,
    TX_CR   = 2'd2
  } tx_state_t;

  // Returns {valid, nibble}; letters have low nibble 1..6, so +9 gives 10..15.
  function automatic logic [4:0] ascii2nib(input logic [7:0] c);
    logic [4:0] res;
    res = 5'b0;
    if (c >= ASCII_0 && c <= 8'h39) begin
      res = {1'b1, c[3:0]};
    end else if ((c >= ASCII_UA && c <= 8'h46) || (c >= ASCII_LA && c <= 8'h66)) begin
      res = {1'b1, c[3:0] + 4'd9};
    end
    return res;
  endfunction

  function automatic logic [7:0] nib2ascii(input logic [3:0] nib, input logic upper);
    logic [7:0] res;
    if (nib < 4'd10) begin
      res = ASCII_0 + {4'h0, nib};
    end else begin
      res = (upper ? ASCII_UA : ASCII_LA) + {4'h0, nib} - 8'd10;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ascii_hex_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ascii_hex_tx                                                    |
// | Purpose  : Sends a latched word as hex digits, MSB first, optional CR      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module ascii_hex_tx
  import ascii_hex_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int APPEND_CR = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_word,
  input  logic              tx_word_valid,
  output logic              tx_word_ready,
  input  logic              tx_upper,
  output logic [7:0]        tx_char,
  output logic              tx_char_valid,
  input  logic              tx_char_ready
);

  localparam int NDIG  = DATA_W / 4;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NDIG - 1);

  tx_state_t         r_state;
  tx_state_t         w_state_nxt;
  logic [DATA_W-1:0] r_word;
  logic              r_upper;
  logic [IDX_W-1:0]  r_idx;
  logic [3:0]        w_nib;

  assign w_nib = r_word[{r_idx, 2'b00} +: 4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= TX_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    tx_char       = ASCII_0;
    tx_char_valid = 1'b0;
    tx_word_ready = 1'b0;
    case (r_state)
      TX_IDLE: begin
        tx_word_ready = 1'b1;
        if (tx_word_valid) begin
          w_state_nxt = TX_DIG;
        end
      end
      TX_DIG: begin
        tx_char_valid = 1'b1;
        tx_char       = nib2ascii(w_nib, r_upper);
        if (tx_char_ready && r_idx == '0) begin
          w_state_nxt = (APPEND_CR != 0) ? TX_CR : TX_IDLE;
        end
      end
      TX_CR: begin
        tx_char_valid = 1'b1;
        tx_char       = ASCII_CR;
        if (tx_char_ready) begin
          w_state_nxt = TX_IDLE;
        end
      end
      default: w_state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word  <= '0;
      r_upper <= 1'b0;
      r_idx   <= '0;
    end else if (r_state == TX_IDLE && tx_word_valid) begin
      r_word  <= tx_word;
      r_upper <= tx_upper;
      r_idx   <= C_LAST_IDX;
    end else if (r_state == TX_DIG && tx_char_ready && r_idx != '0) begin
      r_idx <= r_idx - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ascii_hex_codec.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ascii_hex_codec                                                 |
// | Purpose  : ASCII hex text <-> binary word codec (receiver + transmitter)   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module ascii_hex_codec
  import ascii_hex_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int APPEND_CR = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_char,
  input  logic              rx_char_valid,
  output logic [DATA_W-1:0] rx_word,
  output logic              rx_word_valid,
  output logic              rx_err,
  input  logic [DATA_W-1:0] tx_word,
  input  logic              tx_word_valid,
  output logic              tx_word_ready,
  input  logic              tx_upper,
  output logic [7:0]        tx_char,
  output logic              tx_char_valid,
  input  logic              tx_char_ready
);

  localparam int NDIG  = DATA_W / 4;
  localparam int CNT_W = $clog2(NDIG + 1);
  localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(NDIG - 1);

  logic [DATA_W-1:0] r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic [4:0]        w_dec;
  logic [DATA_W-1:0] w_shift;

  assign w_dec = ascii2nib(rx_char);

  generate
    if (NDIG > 1) begin : g_shift_multi
      assign w_shift = {r_acc[DATA_W-5:0], w_dec[3:0]};
    end else begin : g_shift_single
      assign w_shift = w_dec[3:0];
    end
  endgenerate

  // The accumulator stays right-aligned, so an early CR can publish it as-is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc         <= '0;
      r_cnt         <= '0;
      rx_word       <= '0;
      rx_word_valid <= 1'b0;
      rx_err        <= 1'b0;
    end else begin
      rx_word_valid <= 1'b0;
      rx_err        <= 1'b0;
      if (rx_char_valid) begin
        if (w_dec[4]) begin
          if (r_cnt == C_LAST_CNT) begin
            rx_word       <= w_shift;
            rx_word_valid <= 1'b1;
            r_acc         <= '0;
            r_cnt         <= '0;
          end else begin
            r_acc <= w_shift;
            r_cnt <= r_cnt + 1'b1;
          end
        end else if (rx_char == ASCII_CR) begin
          if (r_cnt != '0) begin
            rx_word       <= r_acc;
            rx_word_valid <= 1'b1;
            r_acc         <= '0;
            r_cnt         <= '0;
          end
        end else if (rx_char != ASCII_LF) begin
          rx_err <= 1'b1;
          r_acc  <= '0;
          r_cnt  <= '0;
        end
      end
    end
  end

  ascii_hex_tx #(
    .DATA_W    (DATA_W),
    .APPEND_CR (APPEND_CR)
  ) u_tx (
    .clk           (clk),
    .rst_n         (rst_n),
    .tx_word       (tx_word),
    .tx_word_valid (tx_word_valid),
    .tx_word_ready (tx_word_ready),
    .tx_upper      (tx_upper),
    .tx_char       (tx_char),
    .tx_char_valid (tx_char_valid),
    .tx_char_ready (tx_char_ready)
  );

endmodule
`default_nettype wire

// File: tb/tb_ascii_hex_codec.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ascii_hex_codec                                              |
// | Purpose  : Self-checking bench for ascii_hex_codec (DATA_W=32, CR on)      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_ascii_hex_codec;

  localparam int DATA_W = 32;
  localparam int NDIG   = DATA_W / 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [7:0]        rx_char;
  logic              rx_char_valid;
  logic [DATA_W-1:0] rx_word;
  logic              rx_word_valid;
  logic              rx_err;
  logic [DATA_W-1:0] tx_word;
  logic              tx_word_valid;
  logic              tx_word_ready;
  logic              tx_upper;
  logic [7:0]        tx_char;
  logic              tx_char_valid;
  logic              tx_char_ready;

  always #5 clk = ~clk;

  ascii_hex_codec #(.DATA_W(DATA_W), .APPEND_CR(1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_char       (rx_char),
    .rx_char_valid (rx_char_valid),
    .rx_word       (rx_word),
    .rx_word_valid (rx_word_valid),
    .rx_err        (rx_err),
    .tx_word       (tx_word),
    .tx_word_valid (tx_word_valid),
    .tx_word_ready (tx_word_ready),
    .tx_upper      (tx_upper),
    .tx_char       (tx_char),
    .tx_char_valid (tx_char_valid),
    .tx_char_ready (tx_char_ready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Receiver reference: value built by arithmetic, digit count, last published word.
  logic [31:0] m_acc  = '0;
  int          m_cnt  = 0;
  logic [31:0] m_word = '0;
  int          rx_vcnt, rx_ecnt;

  logic [7:0]  tx_got[$];
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_char  = '0;

  typedef struct {
    logic [127:0] chars;
    int           n;
    logic [31:0]  word;
    int           nv;
    int           ne;
  } rx_vec_t;

  rx_vec_t vec[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic rx_step(input bit v, input logic [7:0] c);
    bit         ev, ee, is_dig;
    logic [3:0] nib;
    @(negedge clk);
    rx_char_valid = v;
    rx_char       = c;
    ev = 1'b0; ee = 1'b0; is_dig = 1'b1; nib = 4'h0;
    if (v) begin
      if (c >= 8'h30 && c <= 8'h39)      nib = 4'(c - 8'h30);
      else if (c >= 8'h41 && c <= 8'h46) nib = 4'(c - 8'h41 + 8'd10);
      else if (c >= 8'h61 && c <= 8'h66) nib = 4'(c - 8'h61 + 8'd10);
      else                               is_dig = 1'b0;
      if (is_dig) begin
        m_acc = m_acc * 16 + 32'(nib);
        m_cnt++;
        if (m_cnt == NDIG) begin
          m_word = m_acc; ev = 1'b1; m_acc = '0; m_cnt = 0;
        end
      end else if (c == 8'h0D) begin
        if (m_cnt > 0) begin
          m_word = m_acc; ev = 1'b1; m_acc = '0; m_cnt = 0;
        end
      end else if (c != 8'h0A) begin
        ee = 1'b1; m_acc = '0; m_cnt = 0;
      end
    end
    @(posedge clk);
    #1;
    rx_char_valid = 1'b0;
    if (rx_word_valid) rx_vcnt++;
    if (rx_err) rx_ecnt++;
    n_cmp++;
    if (rx_word_valid !== ev || rx_err !== ee || rx_word !== m_word) begin
      n_bad++;
      $display("FAIL rx_step char=%h v=%b: valid=%b err=%b word=%h, expected valid=%b err=%b word=%h",
               c, v, rx_word_valid, rx_err, rx_word, ev, ee, m_word);
    end
  endtask

  // Transmit monitor: logs handshakes, checks stall stability and ready/valid exclusivity.
  always begin
    @(negedge clk);
    #2;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && tx_char_valid) check("tx_char_stable", 64'(tx_char), 64'(prev_char));
      check("tx_word_ready_vs_valid", 64'(tx_word_ready), 64'(!tx_char_valid));
      if (tx_char_valid && tx_char_ready) tx_got.push_back(tx_char);
      prev_stall = tx_char_valid && !tx_char_ready;
      prev_char  = tx_char;
    end
  end

  // mode 0: ready high, 1: ready toggles 1/0, 2: random ready
  task automatic tx_send(input logic [31:0] w, input bit up, input int mode, output int ncyc);
    logic [7:0] exp_q[$];
    logic [3:0] d;
    bit         done;
    int         k;
    for (int i = NDIG - 1; i >= 0; i--) begin
      d = 4'((w >> (4 * i)) & 32'hF);
      if (d < 10) exp_q.push_back(8'h30 + 8'(d));
      else        exp_q.push_back((up ? 8'h41 : 8'h61) + 8'(d) - 8'd10);
    end
    exp_q.push_back(8'h0D);
    @(negedge clk);
    tx_got.delete();
    tx_word = w; tx_upper = up; tx_word_valid = 1'b1; tx_char_ready = 1'b1;
    #3;
    k = 0;
    while (!tx_word_ready && k < 50) begin
      @(negedge clk); #3; k++;
    end
    check("tx_accept_ready", 64'(tx_word_ready), 64'd1);
    @(negedge clk);
    tx_word_valid = 1'b0;
    tx_word       = $urandom;
    tx_upper      = ~up;
    ncyc = 0;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      if (c > 0) @(negedge clk);
      case (mode)
        0:       tx_char_ready = 1'b1;
        1:       tx_char_ready = (c % 2 == 0);
        default: tx_char_ready = 1'($urandom_range(0, 1));
      endcase
      #3;
      if (!tx_char_valid) done = 1'b1;
      else ncyc++;
    end
    check("tx_done_in_budget", 64'(done), 64'd1);
    check("tx_len", 64'(tx_got.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < tx_got.size()) check("tx_char_seq", 64'(tx_got[i]), 64'(exp_q[i]));
    end
    check("tx_ready_after", 64'(tx_word_ready), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          nc;
    logic [7:0]  ch;
    int          k;

    vec[0] = '{{64'h0, "DEADbeef"},              8, 32'hDEADBEEF, 1, 0};
    vec[1] = '{{104'h0, "1F", 8'h0D},            3, 32'h0000001F, 1, 0};
    vec[2] = '{{112'h0, 8'h0A, 8'h0D},           2, 32'h0000001F, 0, 0};
    vec[3] = '{{104'h0, "12G"},                  3, 32'h0000001F, 0, 1};
    vec[4] = '{{64'h0, "00000005"},              8, 32'h00000005, 1, 0};
    vec[5] = '{"abcdef0123456789",              16, 32'h23456789, 2, 0};
    vec[6] = '{{112'h0, "A", 8'h0D},             2, 32'h0000000A, 1, 0};
    vec[7] = '{{96'h0, "9Z", 8'h0D, 8'h0A},      4, 32'h0000000A, 0, 1};

    rst_n = 1'b0;
    rx_char = '0; rx_char_valid = 1'b0;
    tx_word = '0; tx_word_valid = 1'b0; tx_upper = 1'b0; tx_char_ready = 1'b0;
    #2;
    check("reset_rx_word", 64'(rx_word), 64'd0);
    check("reset_rx_word_valid", 64'(rx_word_valid), 64'd0);
    check("reset_rx_err", 64'(rx_err), 64'd0);
    check("reset_tx_char", 64'(tx_char), 64'h30);
    check("reset_tx_char_valid", 64'(tx_char_valid), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #2;
    check("reset_tx_word_ready", 64'(tx_word_ready), 64'd1);

    // Table-driven receive sequences
    for (int v = 0; v < 8; v++) begin
      rx_vcnt = 0; rx_ecnt = 0;
      for (int i = 0; i < vec[v].n; i++) begin
        ch = vec[v].chars[8 * (vec[v].n - 1 - i) +: 8];
        rx_step(1'b1, ch);
      end
      rx_step(1'b0, 8'h00);
      check("vec_word", 64'(rx_word), 64'(vec[v].word));
      check("vec_valid_pulses", 64'(rx_vcnt), 64'(vec[v].nv));
      check("vec_err_pulses", 64'(rx_ecnt), 64'(vec[v].ne));
    end

    // Transmit: stalled upper-case, then full-rate lower-case
    tx_send(32'h0000ABCD, 1'b1, 1, nc);
    check("tx_toggle_cycles", 64'(nc), 64'd17);
    tx_send(32'h0000ABCD, 1'b0, 0, nc);
    check("tx_fullrate_cycles", 64'(nc), 64'd9);

    // Random concurrent receive and transmit traffic
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          int r;
          logic [3:0] d;
          r = $urandom_range(0, 9);
          d = 4'($urandom_range(0, 15));
          if (r == 4)      ch = 8'h0D;
          else if (r == 5) ch = 8'h0A;
          else if (r == 6) ch = 8'($urandom);
          else if (d < 10) ch = 8'h30 + 8'(d);
          else             ch = ($urandom_range(0, 1) ? 8'h41 : 8'h61) + 8'(d) - 8'd10;
          rx_step($urandom_range(0, 3) != 0, ch);
        end
      end
      begin
        for (int i = 0; i < 8; i++) begin
          tx_send($urandom, 1'($urandom_range(0, 1)), 2, nc);
        end
      end
    join

    // Reset in the middle of a receive and after the third transmitted digit
    rx_step(1'b1, "1"); rx_step(1'b1, "2"); rx_step(1'b1, "3");
    @(negedge clk);
    tx_got.delete();
    tx_word = 32'h12345678; tx_upper = 1'b1; tx_word_valid = 1'b1; tx_char_ready = 1'b1;
    @(negedge clk);
    tx_word_valid = 1'b0;
    k = 0;
    #3;
    while (tx_got.size() < 3 && k < 20) begin
      @(negedge clk); #3; k++;
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    m_acc = '0; m_cnt = 0; m_word = '0;
    check("rst_digits_before", 64'(tx_got.size()), 64'd3);
    check("rst_rx_word", 64'(rx_word), 64'd0);
    check("rst_rx_word_valid", 64'(rx_word_valid), 64'd0);
    check("rst_rx_err", 64'(rx_err), 64'd0);
    check("rst_tx_char", 64'(tx_char), 64'h30);
    check("rst_tx_char_valid", 64'(tx_char_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tx_got.delete();
    for (int i = 0; i < 10; i++) rx_step(1'b0, 8'h00);
    check("post_rst_no_tx_chars", 64'(tx_got.size()), 64'd0);
    check("post_rst_tx_word_ready", 64'(tx_word_ready), 64'd1);
    rx_vcnt = 0;
    for (int i = 0; i < 7; i++) rx_step(1'b1, "0");
    rx_step(1'b1, "1");
    rx_step(1'b0, 8'h00);
    check("post_rst_word", 64'(rx_word), 64'h00000001);
    check("post_rst_pulses", 64'(rx_vcnt), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ascii_hex_codec.md
ASCII_HEX_CODEC -- requirements
Module: ascii_hex_codec

Interface
REQ-001 SHALL have parameter DATA_W, default 32, word width in bits; legal values are multiples of 4 from 4 to 64.
REQ-002 SHALL have parameter APPEND_CR, default 1; when 1, the transmitter appends 8'h0D after the last digit.
REQ-003 SHALL derive NDIG = DATA_W/4 and CNT_W = $clog2(NDIG+1) internally.
REQ-004 clk  in  1  single clock for all logic, rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 rx_char  in  8  ASCII character from the UART receiver.
REQ-007 rx_char_valid  in  1  rx_char is sampled on this cycle; no backpressure.
REQ-008 rx_word  out  DATA_W  assembled word, held stable until the next completion.
REQ-009 rx_word_valid  out  1  one-cycle pulse when rx_word updates.
REQ-010 rx_err  out  1  one-cycle pulse when an illegal character arrives.
REQ-011 tx_word  in  DATA_W  word to send as hex text.
REQ-012 tx_word_valid  in  1  tx_word offered.
REQ-013 tx_word_ready  out  1  high only in TX_IDLE.
REQ-014 tx_upper  in  1  1 selects 'A'-'F', 0 selects 'a'-'f'; sampled at word accept.
REQ-015 tx_char  out  8  ASCII character to the UART transmitter.
REQ-016 tx_char_valid  out  1  tx_char offered.
REQ-017 tx_char_ready  in  1  UART transmitter accepts tx_char.

Function
REQ-018 Receive: accepted digits are '0'-'9' (0x30-0x39), 'a'-'f' (0x61-0x66) and 'A'-'F' (0x41-0x46); each digit shifts into a DATA_W shift register MSB-first (acc <= {acc[DATA_W-5:0], nibble}) and increments the digit counter.
REQ-019 When the NDIG-th digit is accepted at cycle t, rx_word SHALL take the accumulated value and rx_word_valid SHALL pulse at t+1, and the counter and accumulator SHALL clear.
REQ-020 CR (0x0D) with count ≥1 SHALL complete the word early, zero-extended and right-aligned, with the same t+1 timing.
REQ-021 CR with count 0, and LF (0x0A) in any state, SHALL be ignored without an error.
REQ-022 Any other character SHALL pulse rx_err at t+1 and clear the counter and accumulator; rx_word SHALL be unchanged.
REQ-023 The receiver SHALL never stall; one character per cycle is legal.
REQ-024 Transmit FSM states: TX_IDLE, TX_DIG, TX_CR.
REQ-025 TX_IDLE: on tx_word_valid && tx_word_ready, latch tx_word and tx_upper, set the digit index to NDIG-1, and go to TX_DIG; tx_char_valid is high from the next cycle.
REQ-026 TX_DIG: tx_char = ASCII of nibble[index], most significant first; nibbles 0-9 map to 0x30+n, nibbles 10-15 map to 0x41+n-10 (upper) or 0x61+n-10 (lower).
REQ-027 On each tx_char_valid && tx_char_ready, the transmitter SHALL advance; tx_char SHALL stay stable while ready is low.
REQ-028 After digit 0: go to TX_CR if APPEND_CR=1, otherwise go to TX_IDLE.
REQ-029 TX_CR: tx_char = 0x0D; on the handshake, go to TX_IDLE.
REQ-030 The minimum transmit time is NDIG+APPEND_CR cycles with ready held high.
REQ-031 The transmit FSM SHALL accept no new word until it is back in TX_IDLE; tx_word_ready SHALL be low in TX_DIG and TX_CR.
REQ-032 The receive and transmit paths SHALL be fully independent; simultaneous activity has no interaction.

Reset
REQ-033 Asserting reset SHALL immediately set rx_word=0, rx_word_valid=0, rx_err=0, accumulator=0, count=0, FSM=TX_IDLE, tx_char_valid=0, tx_char=0x30, and tx_word_ready=1 after release.
REQ-034 Reset during a partial receive or a transmit SHALL discard it; no character or word is emitted after release.

Structure
REQ-035 Package ascii_hex_pkg SHALL hold the constants ASCII_0, ASCII_UA, ASCII_LA, ASCII_CR, ASCII_LF, the tx_state enum, and pure functions ascii2nib (returns {valid, nibble}) and nib2ascii(nib, upper).
REQ-036 The transmit FSM SHALL be the single sub-module ascii_hex_tx; the receiver SHALL reside in ascii_hex_codec.

Verification
REQ-037 DATA_W=32: "DEADbeef" one character per cycle -> rx_word=0xDEADBEEF, rx_word_valid pulses once, rx_err never pulses.
REQ-038 "1F", CR -> rx_word=0x0000001F; LF, CR with count 0 -> no pulse of any kind.
REQ-039 "12G" -> rx_err at the cycle after 'G', rx_word unchanged; then "00000005" -> rx_word=0x00000005.
REQ-040 tx_word=0x0000ABCD, tx_upper=1, APPEND_CR=1, tx_char_ready toggled 1/0 -> the sequence 30,30,30,30,41,42,43,44,0D, each character stable while stalled, then tx_word_ready=1.
REQ-041 Same word with tx_upper=0 and ready held high -> the last digits are 61..64, 9 cycles in total.
REQ-042 reset asserted after the third transmitted digit and in the middle of a receive -> outputs are at reset values immediately, and the next "00000001" decodes correctly.
